// File: rtl/sccb_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sccb_cfg_sequencer: replays the camera init ROM into the SCCB sender, then |
// | arbitrates runtime register writes.                       rev 1.0          |
// +----------------------------------------------------------------------------+
module sccb_cfg_sequencer #(
    parameter int ROM_LAT        = 2,
    parameter int RESET_WAIT_CYC = 25000,
    parameter int GAP_CYC        = 256,
    parameter int TIMEOUT_CYC    = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart_i,
    input  logic [15:0] rom_data_i,
    input  logic        rom_valid_i,
    output logic        rom_adv_o,
    output logic        rom_rst_n_o,
    input  logic        usr_req_i,
    input  logic [7:0]  usr_addr_i,
    input  logic [7:0]  usr_data_i,
    output logic        usr_ack_o,
    output logic        sccb_start_o,
    output logic [7:0]  sccb_addr_o,
    output logic [7:0]  sccb_data_o,
    input  logic        sccb_busy_i,
    input  logic        sccb_done_i,
    output logic        init_done_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int c_MAX_A = (RESET_WAIT_CYC > TIMEOUT_CYC) ? RESET_WAIT_CYC : TIMEOUT_CYC;
    localparam int c_MAX_B = (GAP_CYC > ROM_LAT) ? GAP_CYC : ROM_LAT;
    localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ROM_LAT     = c_CNT_W'(ROM_LAT);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD    = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(RESET_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST     = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_ONE         = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ZERO        = '0;
    localparam logic [7:0]         c_COM7        = 8'h12;

    typedef enum logic [3:0] {
        S_ROM_RST    = 4'd0,
        S_ROM_WAIT   = 4'd1,
        S_INIT_ISSUE = 4'd2,
        S_INIT_WAIT  = 4'd3,
        S_SETTLE     = 4'd4,
        S_GAP        = 4'd5,
        S_IDLE       = 4'd6,
        S_USR_ISSUE  = 4'd7,
        S_USR_WAIT   = 4'd8,
        S_USR_GAP    = 4'd9,
        S_ERROR      = 4'd10
    } state_t;

    state_t              state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                start_q, start_d;
    logic                adv_q, adv_d;
    logic                ack_q, ack_d;
    logic                init_done_q, init_done_d;
    logic                err_q, err_d;
    logic                rom_rst_n_q, rom_rst_n_d;
    logic                busy_q, busy_d;
    logic                soft_rst_w;

    // A COM7 write with bit 7 set resets the sensor and needs the long settle.
    assign soft_rst_w = (addr_q == c_COM7) && data_q[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ROM_RST;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            adv_q       <= 1'b0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            rom_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            start_q     <= start_d;
            adv_q       <= adv_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            rom_rst_n_q <= rom_rst_n_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        start_d     = 1'b0;
        adv_d       = 1'b0;
        ack_d       = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;

        case (state_q)
            S_ROM_RST: begin
                init_done_d = 1'b0;
                cnt_d       = c_ROM_LAT;
                state_d     = S_ROM_WAIT;
            end
            S_ROM_WAIT: begin
                if (cnt_q != c_ZERO) begin
                    cnt_d = cnt_q - c_ONE;
                end else if (!rom_valid_i) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_INIT_ISSUE;
                end
            end
            S_INIT_ISSUE: begin
                if (!sccb_busy_i) begin
                    addr_d  = rom_data_i[15:8];
                    data_d  = rom_data_i[7:0];
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                if (sccb_done_i) begin
                    adv_d = 1'b1;
                    if (soft_rst_w) begin
                        cnt_d   = c_SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        cnt_d   = c_GAP_LOAD;
                        state_d = S_GAP;
                    end
                end else if (cnt_q == c_TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_SETTLE, S_GAP: begin
                if (cnt_q == c_ZERO) begin
                    cnt_d   = c_ROM_LAT;
                    state_d = S_ROM_WAIT;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            S_IDLE: begin
                // restart has priority; a concurrent user request simply stays pending
                if (restart_i) begin
                    init_done_d = 1'b0;
                    state_d     = S_ROM_RST;
                end else if (usr_req_i) begin
                    state_d = S_USR_ISSUE;
                end
            end
            S_USR_ISSUE: begin
                if (!sccb_busy_i) begin
                    addr_d  = usr_addr_i;
                    data_d  = usr_data_i;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_USR_WAIT;
                end
            end
            S_USR_WAIT: begin
                if (sccb_done_i) begin
                    ack_d   = 1'b1;
                    cnt_d   = c_GAP_LOAD;
                    state_d = S_USR_GAP;
                end else if (cnt_q == c_TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_USR_GAP: begin
                if (cnt_q == c_ZERO) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            S_ERROR: begin
                if (restart_i) begin
                    err_d       = 1'b0;
                    init_done_d = 1'b0;
                    state_d     = S_ROM_RST;
                end
            end
            default: begin
                state_d = S_ROM_RST;
            end
        endcase

        rom_rst_n_d = (state_d != S_ROM_RST);
        busy_d      = (state_d != S_IDLE) && (state_d != S_ERROR);
    end

    assign rom_adv_o    = adv_q;
    assign rom_rst_n_o  = rom_rst_n_q;
    assign usr_ack_o    = ack_q;
    assign sccb_start_o = start_q;
    assign sccb_addr_o  = addr_q;
    assign sccb_data_o  = data_q;
    assign init_done_o  = init_done_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sccb_cfg_sequencer: directed bench with ROM and SCCB sender models.     |
// |                                                           rev 1.0          |
// +----------------------------------------------------------------------------+
module tb_sccb_cfg_sequencer;

    localparam int ROM_LAT        = 2;
    localparam int RESET_WAIT_CYC = 50;
    localparam int GAP_CYC        = 4;
    localparam int TIMEOUT_CYC    = 100;
    localparam int DONE_DLY       = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] rom_data;
    logic        rom_valid;
    logic        rom_adv;
    logic        rom_rst_n;
    logic        usr_req = 1'b0;
    logic [7:0]  usr_addr = 8'h00;
    logic [7:0]  usr_data = 8'h00;
    logic        usr_ack;
    logic        sccb_start;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_busy;
    logic        sccb_done;
    logic        init_done;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    sccb_cfg_sequencer #(
        .ROM_LAT        (ROM_LAT),
        .RESET_WAIT_CYC (RESET_WAIT_CYC),
        .GAP_CYC        (GAP_CYC),
        .TIMEOUT_CYC    (TIMEOUT_CYC)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart_i    (restart),
        .rom_data_i   (rom_data),
        .rom_valid_i  (rom_valid),
        .rom_adv_o    (rom_adv),
        .rom_rst_n_o  (rom_rst_n),
        .usr_req_i    (usr_req),
        .usr_addr_i   (usr_addr),
        .usr_data_i   (usr_data),
        .usr_ack_o    (usr_ack),
        .sccb_start_o (sccb_start),
        .sccb_addr_o  (sccb_addr),
        .sccb_data_o  (sccb_data),
        .sccb_busy_i  (sccb_busy),
        .sccb_done_i  (sccb_done),
        .init_done_o  (init_done),
        .busy_o       (busy),
        .err_o        (err)
    );

    // ROM model: two-register output pipeline gives the ROM_LAT of 2
    bit [15:0] rom_mem [0:7];
    int        rom_len = 0;
    int        rom_idx = 0;
    bit [16:0] rom_p1 = '0;
    bit [16:0] rom_p2 = '0;

    always @(posedge clk) begin
        if (!rom_rst_n)   rom_idx <= 0;
        else if (rom_adv) rom_idx <= rom_idx + 1;
        rom_p1 <= (rom_idx < rom_len && rom_idx < 8) ? {1'b1, rom_mem[rom_idx[2:0]]} : 17'h0;
        rom_p2 <= rom_p1;
    end
    assign rom_valid = rom_p2[16];
    assign rom_data  = rom_p2[15:0];

    // SCCB sender model; in hang mode it swallows starts and never finishes
    bit hang = 1'b0;
    int s_cnt;
    logic s_busy, s_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_busy <= 1'b0;
            s_done <= 1'b0;
            s_cnt  <= 0;
        end else begin
            s_done <= 1'b0;
            if (sccb_start && !s_busy && !hang) begin
                s_busy <= 1'b1;
                s_cnt  <= DONE_DLY - 1;
            end else if (s_busy) begin
                if (s_cnt == 0) begin
                    s_busy <= 1'b0;
                    s_done <= 1'b1;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end
    assign sccb_busy = s_busy;
    assign sccb_done = s_done;

    // Event recorder
    int        cyc = 0, st_n = 0, adv_n = 0, ack_n = 0, rstlow_n = 0;
    int        viol_n = 0, adv_bad = 0, ack_bad = 0, last_done = -10;
    bit [15:0] st_word [0:63];
    int        st_cyc  [0:63];
    bit        st_init [0:63];
    int        adv_cyc [0:63];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sccb_done) last_done <= cyc;
        if (sccb_start && st_n < 64) begin
            st_word[st_n] <= {sccb_addr, sccb_data};
            st_cyc[st_n]  <= cyc;
            st_init[st_n] <= init_done;
            st_n          <= st_n + 1;
        end
        if (sccb_start && sccb_busy) viol_n <= viol_n + 1;
        if (rom_adv && adv_n < 64) begin
            adv_cyc[adv_n] <= cyc;
            adv_n          <= adv_n + 1;
            if (last_done != cyc - 1) adv_bad <= adv_bad + 1;
        end
        if (usr_ack) begin
            ack_n <= ack_n + 1;
            if (last_done != cyc - 1) ack_bad <= ack_bad + 1;
        end
        if (rst_n && !rom_rst_n) rstlow_n <= rstlow_n + 1;
    end

    logic [22:0] outs;
    assign outs = {rom_rst_n, busy, init_done, err, sccb_start, rom_adv, usr_ack, sccb_addr, sccb_data};

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cond(input int what, input int arg);
        case (what)
            0:       return init_done && !busy;
            1:       return err;
            2:       return st_n >= arg;
            3:       return ack_n >= arg;
            default: return init_done;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int what, input int arg, input int budget);
        int n = 0;
        while (!cond(what, arg) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, cond(what, arg)}, 32'd1);
    endtask

    task automatic load_rom(input bit [15:0] w0, input bit [15:0] w1, input bit [15:0] w2, input int len);
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
        rom_len    = len;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    int b, a, k, r, i1, i2, e;

    initial begin
        // Reset, then init with a user write pending from the start
        load_rom(16'hFF01, 16'h1180, 16'h0420, 3);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {9'b0, outs}, 32'h0);
        #2 rst_n = 1'b1;
        usr_req  = 1'b1;
        usr_addr = 8'h13;
        usr_data = 8'hE5;
        wait_for("init_done_wait", 4, 0, 500);
        chk("init_start_count", st_n, 3);
        chk("init_word0", {16'b0, st_word[0]}, 32'hFF01);
        chk("init_word1", {16'b0, st_word[1]}, 32'h1180);
        chk("init_word2", {16'b0, st_word[2]}, 32'h0420);
        chk("init_adv_count", adv_n, 3);
        wait_for("usr_ack_wait", 3, 1, 200);
        usr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("usr_word", {16'b0, st_word[3]}, 32'h13E5);
        chk("usr_after_init", {31'b0, st_init[3]}, 32'd1);
        chk("usr_ack_count", ack_n, 1);
        chk("usr_no_adv", adv_n, 3);

        // restart and usr_req in the same IDLE cycle
        wait_for("idle_before_restart", 0, 0, 100);
        b = st_n; a = adv_n; k = ack_n; r = rstlow_n;
        usr_req  = 1'b1;
        usr_addr = 8'h2A;
        usr_data = 8'h5C;
        pulse_restart();
        chk("restart_clears_done", {31'b0, init_done}, 32'd0);
        chk("restart_rom_rst", {31'b0, rom_rst_n}, 32'd0);
        wait_for("restart_ack_wait", 3, k + 1, 500);
        usr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rom_rst_one_cycle", rstlow_n - r, 1);
        chk("replay_word0", {16'b0, st_word[b]}, 32'hFF01);
        chk("replay_word2", {16'b0, st_word[b + 2]}, 32'h0420);
        chk("replay_usr_word", {16'b0, st_word[b + 3]}, 32'h2A5C);
        chk("replay_adv_count", adv_n - a, 3);

        // Soft-reset settle versus ordinary gap
        wait_for("idle_before_settle", 0, 0, 100);
        load_rom(16'h1280, 16'h1240, 16'h0420, 3);
        b = st_n; a = adv_n;
        pulse_restart();
        wait_for("settle_init_wait", 0, 0, 800);
        @(negedge clk);
        chk("settle_word0", {16'b0, st_word[b]}, 32'h1280);
        chk("settle_word1", {16'b0, st_word[b + 1]}, 32'h1240);
        i1 = st_cyc[b + 1] - adv_cyc[a];
        i2 = st_cyc[b + 2] - adv_cyc[a + 1];
        chk("settle_min_delay", {31'b0, (i1 >= RESET_WAIT_CYC + ROM_LAT)}, 32'd1);
        chk("settle_minus_gap", i1 - i2, RESET_WAIT_CYC - GAP_CYC);

        // Timeout with a silent sender
        load_rom(16'h0A55, 16'h0000, 16'h0000, 1);
        hang = 1'b1;
        b = st_n; a = adv_n;
        pulse_restart();
        wait_for("timeout_start_wait", 2, b + 1, 100);
        wait_for("timeout_err_wait", 1, 0, 300);
        e = cyc;
        chk("timeout_cycles", e - st_cyc[b], TIMEOUT_CYC);
        chk("timeout_busy", {31'b0, busy}, 32'd0);
        chk("timeout_no_done", {31'b0, init_done}, 32'd0);
        chk("timeout_no_adv", adv_n - a, 0);
        hang = 1'b0;
        pulse_restart();
        chk("restart_clears_err", {31'b0, err}, 32'd0);
        wait_for("recover_init_wait", 0, 0, 300);
        @(negedge clk);
        chk("recover_word", {16'b0, st_word[b + 1]}, 32'h0A55);
        chk("recover_adv", adv_n - a, 1);

        // Asynchronous reset during INIT_WAIT
        load_rom(16'hFF01, 16'h1180, 16'h0420, 3);
        b = st_n;
        pulse_restart();
        wait_for("midreset_start_wait", 2, b + 1, 100);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {9'b0, outs}, 32'h0);
        repeat (3) @(negedge clk);
        b = st_n;
        #2 rst_n = 1'b1;
        wait_for("midreset_init_wait", 0, 0, 500);
        @(negedge clk);
        chk("midreset_start_count", st_n - b, 3);
        chk("midreset_word0", {16'b0, st_word[b]}, 32'hFF01);

        chk("start_while_busy", viol_n, 0);
        chk("adv_timing", adv_bad, 0);
        chk("ack_timing", ack_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
